add128_slice_seq: RTL
=====================

// Module: add128_slice_seq
// PURPOSE
//  Multi-cycle 128-bit adder sequencer that time-shares one external combinational
//  16-bit carry-select adder slice (CSA_16bit).
//  - Accepts a 128-bit operand pair over a valid/ready handshake.
//  - Feeds the slice one 16-bit chunk per cycle, LSB first, rippling carry-out into the
//    next carry-in through a register; the slice's Sum/Cout are consumed back the same cycle.
//  - Returns the full 128-bit Sum and Cout over a valid/ready handshake.
//  - Area-reduced alternative to the fully unrolled 128-bit adder.
// PARAMETERS
//  WIDTH   128  total operand width; must be an integer multiple of SLICE
//  SLICE   16   slice width, matched to the external adder
//  NSLICE  WIDTH/SLICE (localparam, 8)  number of RUN cycles per addition
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      operand request valid
//  in_ready   out  1      sequencer can accept operands
//  X          in   WIDTH  operand A
//  Y          in   WIDTH  operand B
//  Cin        in   1      carry-in of full addition
//  add_x      out  SLICE  slice operand A to adder
//  add_y      out  SLICE  slice operand B to adder
//  add_cin    out  1      slice carry-in to adder
//  add_sum    in   SLICE  slice sum from adder (combinational, same cycle)
//  add_cout   in   1      slice carry-out from adder (combinational, same cycle)
//  out_valid  out  1      Sum/Cout valid
//  out_ready  in   1      consumer accepts result
//  Sum        out  WIDTH  registered 128-bit sum
//  Cout       out  1      registered final carry-out
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=IDLE, idx=0, carry=0, Sum=0, Cout=0, out_valid=0.
//   - in_ready is gated by rst_n: 0 while rst_n=0.
//   - Reset wins over every other event, including mid-RUN; partial result is discarded.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1. On in_valid&in_ready: latch X,Y into op regs; carry<=Cin; idx<=0; ->RUN.
//   - RUN: in_ready=0.
//     - add_x=Xr[idx*SLICE+:SLICE], add_y=Yr[idx*SLICE+:SLICE], add_cin=carry.
//     - Each edge: Sum[idx*SLICE+:SLICE]<=add_sum; carry<=add_cout; idx<=idx+1.
//     - When idx==NSLICE-1: Cout<=add_cout; idx<=0; ->DONE.
//   - DONE: out_valid=1, in_ready=0. On out_ready: ->IDLE, out_valid falls next cycle.
//  Outside RUN: add_x, add_y, add_cin driven to 0.
//  Latency/throughput:
//   - Accept edge at cycle 0; out_valid=1 from cycle NSLICE (8).
//   - Minimum issue interval NSLICE+2 cycles (RUN x8, DONE x1, IDLE x1).
//  Sum/Cout:
//   - Stable throughout DONE, however long out_ready stays low.
//   - Hold in IDLE; overwritten slice-by-slice in the next RUN.
//   - Meaningful only while out_valid=1.
//  Input handling:
//   - in_valid outside IDLE is ignored; the upstream holds the request until in_ready.
//   - X/Y/Cin changes after acceptance have no effect on the result.
//  Arithmetic: {Cout,Sum} = X + Y + Cin, exact modulo 2^(WIDTH+1). No overflow flag.
//  idx width: $clog2(NSLICE); never exceeds NSLICE-1.
// TESTING
//  1 Reset: hold rst_n=0 for 2 cycles.
//    -> out_valid=0, in_ready=0, Sum=0, Cout=0, add_*=0. After release: in_ready=1.
//  2 Full ripple: X=2^128-1, Y=0, Cin=1.
//    -> add_cin=1 on every RUN cycle; out_valid at cycle 8; Sum=0, Cout=1.
//  3 Mid carry: X=0x0000..0000_FFFFFFFF_FFFFFFFF, Y=1, Cin=0.
//    -> Sum=0x0000..0001_00000000_00000000, Cout=0.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE, in_valid=1 throughout.
//    -> out_valid, Sum, Cout stable; in_ready=0; no new accept until cycle after out_ready=1.
//  5 Reset mid-op: rst_n=0 at RUN idx=3.
//    -> next cycle IDLE, out_valid=0, Sum=0. No result is ever emitted for that request.
//  6 Random: 1000 vectors, random in_valid/out_ready gaps.
//    -> {Cout,Sum} matches X+Y+Cin; out_valid exactly 8 cycles after each accept.

Source files
------------

// File: rtl/add128_slice_seq.sv
// ============================================================================
// add128_slice_seq : wide adder sequenced through one external 16-bit slice,
// LSB chunk first, with the carry rippled through a register.   Revision: 1.0
// ============================================================================
`default_nettype none

module add128_slice_seq #(
   parameter int WIDTH = 128,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Cin,
   output logic [SLICE-1:0] add_x,
   output logic [SLICE-1:0] add_y,
   output logic             add_cin,
   input  logic [SLICE-1:0] add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic                          carry_q, carry_d;
   logic [NSLICE-1:0][SLICE-1:0]  xr_q, xr_d;
   logic [NSLICE-1:0][SLICE-1:0]  yr_q, yr_d;
   logic [NSLICE-1:0][SLICE-1:0]  sum_q, sum_d;
   logic                          cout_q, cout_d;
   logic                          last_w;

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign last_w    = (idx_q == IW'(NSLICE - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               xr_d    = X;
               yr_d    = Y;
               carry_d = Cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Slice result is combinational, so it is captured on this same edge.
            add_x        = xr_q[idx_q];
            add_y        = yr_q[idx_q];
            add_cin      = carry_q;
            sum_d[idx_q] = add_sum;
            carry_d      = add_cout;
            if (last_w) begin
               cout_d  = add_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         xr_q    <= '0;
         yr_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

endmodule

`default_nettype wire
